// File: rtl/testio_wb_arbiter_if.sv
// Bus bundle for the testio_wb round-robin arbiter: the per-master request side and the shared slave side.
// The arbiter connects through the master modport (it masters the slave); the environment uses slave.
interface testio_wb_arbiter_if #(
   parameter int BUS_WIDTH   = 32,
   parameter int BUS_MASK    = 4,
   parameter int NUM_MASTERS = 2
);
   logic [NUM_MASTERS-1:0]           m_cyc_i;
   logic [NUM_MASTERS-1:0]           m_stb_i;
   logic [NUM_MASTERS-1:0]           m_we_i;
   logic [NUM_MASTERS*BUS_WIDTH-1:0] m_addr_i;
   logic [NUM_MASTERS*BUS_WIDTH-1:0] m_data_i;
   logic [NUM_MASTERS*BUS_MASK-1:0]  m_sel_i;
   logic [NUM_MASTERS-1:0]           m_ack_o;
   logic [NUM_MASTERS-1:0]           m_err_o;
   logic [BUS_WIDTH-1:0]             m_data_o;

   logic                             wb_cyc_o;
   logic                             wb_stb_o;
   logic                             wb_we_o;
   logic [BUS_WIDTH-1:0]             wb_addr_o;
   logic [BUS_WIDTH-1:0]             wb_data_o;
   logic [BUS_MASK-1:0]              wb_sel_o;
   logic                             wb_ack_i;
   logic                             wb_err_i;
   logic [BUS_WIDTH-1:0]             wb_data_i;

   modport master (
      input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
      output m_ack_o, m_err_o, m_data_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
      input  wb_ack_i, wb_err_i, wb_data_i
   );

   modport slave (
      output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
      input  m_ack_o, m_err_o, m_data_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
      output wb_ack_i, wb_err_i, wb_data_i
   );
endinterface

// File: rtl/testio_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one testio_wb slave among NUM_MASTERS masters; grant locked per cycle.
// Define TI_ARB_TIMEOUT_EN to add a watchdog that aborts stalled transfers with a bus error.
module testio_wb_arbiter #(
   parameter int BUS_WIDTH      = 32,
   parameter int BUS_MASK       = 4,
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   testio_wb_arbiter_if.master    bus,
   output logic [NUM_MASTERS-1:0] grant_o,
   output logic                   busy_o
);

   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1
`ifdef TI_ARB_TIMEOUT_EN
      ,
      ST_ABORT = 2'd2
`endif
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          gidx_q, gidx_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [PW-1:0]          pick_idx;
   logic [PW-1:0]          cand;
   logic                   pick_vld;

   logic                   g_cyc, g_stb, g_we;
   logic [BUS_WIDTH-1:0]   g_addr, g_wdata;
   logic [BUS_MASK-1:0]    g_sel;
   logic                   release_g;
   logic                   expire;

   // Search starts just after the last released master, so it gets lowest priority next.
   always_comb begin
      pick_idx = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = PW'((int'(ptr_q) + i) % NUM_MASTERS);
         if (!pick_vld && bus.m_cyc_i[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      g_cyc   = bus.m_cyc_i[gidx_q];
      g_stb   = bus.m_stb_i[gidx_q];
      g_we    = bus.m_we_i[gidx_q];
      g_addr  = bus.m_addr_i[int'(gidx_q)*BUS_WIDTH +: BUS_WIDTH];
      g_wdata = bus.m_data_i[int'(gidx_q)*BUS_WIDTH +: BUS_WIDTH];
      g_sel   = bus.m_sel_i[int'(gidx_q)*BUS_MASK +: BUS_MASK];
   end

`ifdef TI_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        stall;

   always_comb begin
      stall  = (state_q == ST_GRANT) && g_cyc && g_stb && !bus.wb_ack_i && !bus.wb_err_i;
      expire = stall && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
      cnt_d  = (stall && !expire) ? cnt_q + 16'd1 : 16'd0;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) cnt_q <= 16'd0;
      else         cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   // NOTE: every output and next-state variable gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      ptr_d        = ptr_q;
      release_g    = 1'b0;
      bus.wb_cyc_o  = 1'b0;
      bus.wb_stb_o  = 1'b0;
      bus.wb_we_o   = 1'b0;
      bus.wb_addr_o = '0;
      bus.wb_data_o = '0;
      bus.wb_sel_o  = '0;
      bus.m_ack_o   = '0;
      bus.m_err_o   = '0;
      bus.m_data_o  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_GRANT;
               gidx_d  = pick_idx;
               grant_d = NUM_MASTERS'(1) << pick_idx;
            end
         end
         ST_GRANT: begin
            bus.wb_cyc_o        = g_cyc & ~expire;
            bus.wb_stb_o        = g_cyc & g_stb & ~expire;
            bus.wb_we_o         = g_we;
            bus.wb_addr_o       = g_addr;
            bus.wb_data_o       = g_wdata;
            bus.wb_sel_o        = g_sel;
            bus.m_ack_o[gidx_q] = bus.wb_ack_i;
            bus.m_err_o[gidx_q] = bus.wb_err_i | expire;
            bus.m_data_o        = bus.wb_data_i;
            if (!g_cyc) release_g = 1'b0 | 1'b1;
`ifdef TI_ARB_TIMEOUT_EN
            else if (expire) state_d = ST_ABORT;
`endif
         end
`ifdef TI_ARB_TIMEOUT_EN
         // Slave side stays quiet and late responses are dropped until the master gives up.
         ST_ABORT: begin
            if (!g_cyc) release_g = 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (release_g) begin
         state_d = ST_IDLE;
         grant_d = '0;
         ptr_d   = gidx_q;
      end

      // Outputs are forced quiet while reset is asserted, even before the reset edge lands.
      if (!rstn_i) begin
         bus.wb_cyc_o  = 1'b0;
         bus.wb_stb_o  = 1'b0;
         bus.wb_we_o   = 1'b0;
         bus.wb_addr_o = '0;
         bus.wb_data_o = '0;
         bus.wb_sel_o  = '0;
         bus.m_ack_o   = '0;
         bus.m_err_o   = '0;
         bus.m_data_o  = '0;
      end
   end

   // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking assignments.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= PW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q != ST_IDLE);

endmodule
